// File: rtl/simple_adder.sv
// Bit-serial 2-bit adder: takes two operands MSB-first over two cycles framed
// by en_i, and returns the 3-bit sum MSB-first over three cycles framed by en_o.
module simple_adder (
  input  logic clk,
  input  logic rst_n,
  input  logic ina,
  input  logic inb,
  input  logic en_i,
  output logic out,
  output logic en_o
);

  typedef enum logic [2:0] {
    IDLE,
    RD_LSB,
    OUT2,
    OUT1,
    OUT0
  } state_t;

  state_t     state, state_nxt;
  logic       a_msb, a_msb_nxt;
  logic       b_msb, b_msb_nxt;
  logic [2:0] sum_r, sum_nxt;
  logic       out_nxt, en_o_nxt;

  // Widened before adding so the carry lands in bit 2 (3+3=6 always fits).
  function automatic logic [2:0] add2(input logic [1:0] a, input logic [1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  always_comb begin
    state_nxt = state;
    a_msb_nxt = a_msb;
    b_msb_nxt = b_msb;
    sum_nxt   = sum_r;
    out_nxt   = 1'b0;
    en_o_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (en_i) begin
          a_msb_nxt = ina;
          b_msb_nxt = inb;
          state_nxt = RD_LSB;
        end
      end
      RD_LSB: begin
        sum_nxt   = add2({a_msb, ina}, {b_msb, inb});
        out_nxt   = sum_nxt[2];
        en_o_nxt  = 1'b1;
        state_nxt = OUT2;
      end
      OUT2: begin
        out_nxt   = sum_r[1];
        en_o_nxt  = 1'b1;
        state_nxt = OUT1;
      end
      OUT1: begin
        out_nxt   = sum_r[0];
        en_o_nxt  = 1'b1;
        state_nxt = OUT0;
      end
      OUT0: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_msb <= 1'b0;
      b_msb <= 1'b0;
      sum_r <= 3'd0;
      out   <= 1'b0;
      en_o  <= 1'b0;
    end else begin
      state <= state_nxt;
      a_msb <= a_msb_nxt;
      b_msb <= b_msb_nxt;
      sum_r <= sum_nxt;
      out   <= out_nxt;
      en_o  <= en_o_nxt;
    end
  end

endmodule

// File: tb/tb_simple_adder.sv
// Scoreboard bench for simple_adder: stimulus pushes expected (bit, cycle)
// pairs, a negedge monitor pops and compares whenever en_o is high.
module tb_simple_adder;

  logic clk = 1'b0;
  logic rst_n;
  logic ina;
  logic inb;
  logic en_i;
  logic out;
  logic en_o;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic b;
    int   c;
  } exp_t;

  exp_t q[$];

  simple_adder dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ina  (ina),
    .inb  (inb),
    .en_i (en_i),
    .out  (out),
    .en_o (en_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected sum bits appear after E1, E2, E3 (E0 is the next edge).
  task automatic push_sum(input logic [2:0] s);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      e.b = s[2-i];
      e.c = cyc + 2 + i;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] a, input logic [1:0] b, input logic [2:0] s);
    push_sum(s);
    en_i = 1'b1;
    ina  = a[1];
    inb  = b[1];
    idle(1);
    en_i = 1'b0;
    ina  = a[0];
    inb  = b[0];
    idle(1);
    ina  = 1'b0;
    inb  = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (en_o) begin
      if (q.size() == 0) begin
        check("spurious_en_o", 1, 0);
      end else begin
        e = q.pop_front();
        check("sum_bit", out, e.b);
        check("sum_bit_cycle", cyc, e.c);
      end
    end else begin
      check("idle_out_zero", out, 0);
      if (q.size() > 0 && q[0].c <= cyc) begin
        e = q.pop_front();
        check("missed_sum_bit", 0, 1);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    en_i  = 1'b0;
    ina   = 1'b0;
    inb   = 1'b0;
    #2;
    check("reset_out", out, 0);
    check("reset_en_o", en_o, 0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Basic vectors: 3+2=5, 0+0=0, 3+3=6, 1+2=3 on a 7-cycle period.
    send(2'd3, 2'd2, 3'd5); idle(5);
    send(2'd0, 2'd0, 3'd0); idle(5);
    send(2'd3, 2'd3, 3'd6); idle(5);
    send(2'd1, 2'd2, 3'd3); idle(5);

    for (int i = 0; i < 4; i++) begin
      send(2'd3, 2'd2, 3'd5);
      idle(5);
    end
    // Minimum spacing: next en_i sampled at E5.
    for (int i = 0; i < 4; i++) begin
      send(2'd3, 2'd2, 3'd5);
      idle(3);
    end
    idle(4);

    // en_i pulses in RD_LSB, OUT2 and OUT0 must be ignored.
    push_sum(3'd5);
    en_i = 1'b1; ina = 1'b1; inb = 1'b1;
    idle(1);
    en_i = 1'b1; ina = 1'b1; inb = 1'b0;
    idle(1);
    en_i = 1'b1; ina = 1'b1; inb = 1'b1;
    idle(1);
    en_i = 1'b0;
    idle(1);
    en_i = 1'b1; ina = 1'b1; inb = 1'b1;
    idle(1);
    en_i = 1'b0; ina = 1'b0; inb = 1'b0;
    idle(8);

    // Asynchronous reset during OUT1 aborts the transaction.
    send(2'd3, 2'd2, 3'd5);
    idle(1);
    rst_n = 1'b0;
    #1;
    check("abort_out", out, 0);
    check("abort_en_o", en_o, 0);
    q.delete();
    idle(1);
    rst_n = 1'b1;
    idle(6);
    send(2'd3, 2'd2, 3'd5);
    idle(6);

    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
